// File: rtl/reg_file_clken.sv
// Parametrised register file: one write port, two registered read ports, optional
// write-to-read bypass, optional hardwired-zero entry 0 and per-entry valid bits.
module reg_file_clken #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             rv0,
  output logic             rv1
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic             wr_ok;
  logic [AW-1:0]    ra     [2];
  logic [WIDTH-1:0] rd_nxt [2];
  logic             rv_nxt [2];

  assign ra[0] = ra0;
  assign ra[1] = ra1;

  always_comb begin
    wr_ok = we && ({1'b0, waddr} < DEPTH_W) && !(ZERO_REG && (waddr == '0));
  end

  // An accepted write overrides a same-cycle clear for its own entry.
  always_comb begin
    valid_nxt = valid;
    if (clr)
      valid_nxt = '0;
    if (wr_ok)
      valid_nxt[waddr] = 1'b1;
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_nxt[p] = '0;
      rv_nxt[p] = 1'b0;
      if ({1'b0, ra[p]} < DEPTH_W) begin
        if (ZERO_REG && (ra[p] == '0)) begin
          rv_nxt[p] = 1'b1;
        end else if (BYPASS && wr_ok && (waddr == ra[p])) begin
          rd_nxt[p] = wdata;
          rv_nxt[p] = 1'b1;
        end else begin
          rd_nxt[p] = mem[ra[p]];
          rv_nxt[p] = valid[ra[p]] && !clr;
        end
      end
    end
  end

  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      valid <= '0;
      rd0   <= '0;
      rd1   <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else if (clk_en) begin
      if (wr_ok)
        mem[waddr] <= wdata;
      valid <= valid_nxt;
      rd0   <= rd_nxt[0];
      rd1   <= rd_nxt[1];
      rv0   <= rv_nxt[0];
      rv1   <= rv_nxt[1];
    end
  end

endmodule

// File: tb/tb_reg_file_clken.sv
// Bench for reg_file_clken: three configurations share one stimulus stream; expected
// outputs are queued as stimulus is driven and compared after each clock edge.
module tb_reg_file_clken;

  localparam int W = 16;

  logic          clk_n = 1'b0;
  logic          rst_n, clk_en, clr, we;
  logic [2:0]    waddr, ra0, ra1;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rd0_o [3];
  logic [W-1:0]  rd1_o [3];
  logic          rv0_o [3];
  logic          rv1_o [3];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk_n = ~clk_n;

  // 0: BYPASS=1 DEPTH=8, 1: BYPASS=0 DEPTH=8, 2: ZERO_REG=1 DEPTH=6
  reg_file_clken #(.WIDTH(W), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
    .clk_n(clk_n), .rst_n(rst_n), .clk_en(clk_en), .clr(clr), .we(we),
    .waddr(waddr), .wdata(wdata), .ra0(ra0), .ra1(ra1),
    .rd0(rd0_o[0]), .rd1(rd1_o[0]), .rv0(rv0_o[0]), .rv1(rv1_o[0]));

  reg_file_clken #(.WIDTH(W), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
    .clk_n(clk_n), .rst_n(rst_n), .clk_en(clk_en), .clr(clr), .we(we),
    .waddr(waddr), .wdata(wdata), .ra0(ra0), .ra1(ra1),
    .rd0(rd0_o[1]), .rd1(rd1_o[1]), .rv0(rv0_o[1]), .rv1(rv1_o[1]));

  reg_file_clken #(.WIDTH(W), .DEPTH(6), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zr (
    .clk_n(clk_n), .rst_n(rst_n), .clk_en(clk_en), .clr(clr), .we(we),
    .waddr(waddr), .wdata(wdata), .ra0(ra0), .ra1(ra1),
    .rd0(rd0_o[2]), .rd1(rd1_o[2]), .rv0(rv0_o[2]), .rv1(rv1_o[2]));

  typedef struct {
    logic         en, rst, cl, wr;
    logic [2:0]   wa;
    logic [W-1:0] wd;
    logic [2:0]   r0, r1;
    logic [W-1:0] e_rd0;
    logic         e_rv0;
    logic [W-1:0] e_rd1;
    logic         e_rv1;
  } vec_t;

  typedef struct {
    int unsigned  dut;
    string        name;
    logic [W-1:0] rd0;
    logic         rv0;
    logic [W-1:0] rd1;
    logic         rv1;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];

  task automatic drive(input logic en, input logic rst, input logic cl, input logic wr,
                       input logic [2:0] wa, input logic [W-1:0] wd,
                       input logic [2:0] r0, input logic [2:0] r1);
    clk_en = en; rst_n = rst; clr = cl; we = wr;
    waddr = wa; wdata = wd; ra0 = r0; ra1 = r1;
  endtask

  task automatic push(input int unsigned dut, input string name,
                      input logic [W-1:0] e_rd0, input logic e_rv0,
                      input logic [W-1:0] e_rd1, input logic e_rv1);
    exp_t e;
    e.dut = dut; e.name = name;
    e.rd0 = e_rd0; e.rv0 = e_rv0; e.rd1 = e_rd1; e.rv1 = e_rv1;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_n);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (rd0_o[e.dut] !== e.rd0 || rv0_o[e.dut] !== e.rv0 ||
          rd1_o[e.dut] !== e.rd1 || rv1_o[e.dut] !== e.rv1) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got rd0=%h rv0=%b rd1=%h rv1=%b, want rd0=%h rv0=%b rd1=%h rv1=%b",
                 e.name, e.dut, rd0_o[e.dut], rv0_o[e.dut], rd1_o[e.dut], rv1_o[e.dut],
                 e.rd0, e.rv0, e.rd1, e.rv1);
      end
    end
  endtask

  initial begin
    //          en    rst   clr   we    wa    wd         r0    r1    rd0        rv0   rd1        rv1
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1111, 3'd1, 3'd2, 16'h1111, 1'b1, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h2222, 3'd3, 3'd4, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h4444, 3'd1, 3'd2, 16'h1111, 1'b1, 16'h2222, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h8888, 3'd3, 3'd4, 16'h4444, 1'b1, 16'h8888, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 16'h4444, 1'b1, 16'h8888, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'hCCCC, 3'd5, 3'd5, 16'hCCCC, 1'b1, 16'hCCCC, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'hDDDD, 3'd0, 3'd1, 16'hCCCC, 1'b1, 16'hCCCC, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'hDDDD, 3'd2, 3'd1, 16'hCCCC, 1'b1, 16'hCCCC, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'hDDDD, 3'd0, 3'd1, 16'hCCCC, 1'b1, 16'hCCCC, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 16'h2222, 1'b1, 16'hCCCC, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 16'hFFFF, 3'd6, 3'd1, 16'hFFFF, 1'b1, 16'h1111, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd1, 16'hFFFF, 1'b1, 16'h1111, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd7, 16'h2222, 1'b0, 16'h0000, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h1234, 3'd0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'hABCD, 3'd7, 3'd6, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].rst, tbl[i].cl, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1);
      push(0, $sformatf("tbl[%0d]", i), tbl[i].e_rd0, tbl[i].e_rv0, tbl[i].e_rd1, tbl[i].e_rv1);
      tick();
    end

    // Same-edge write/read: forwarded with bypass, old contents without.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'hCCCC, 3'd5, 3'd5);
    push(0, "byp_same_edge",   16'hCCCC, 1'b1, 16'hCCCC, 1'b1);
    push(1, "nobyp_same_edge", 16'h0000, 1'b0, 16'h0000, 1'b0);
    push(2, "zr_write_last",   16'hCCCC, 1'b1, 16'hCCCC, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd0);
    push(1, "nobyp_next_edge", 16'hCCCC, 1'b1, 16'h0000, 1'b0);
    push(2, "zr_read_last",    16'hCCCC, 1'b1, 16'h0000, 1'b1);
    tick();

    // Hardwired-zero entry and out-of-range addresses.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'hABCD, 3'd0, 3'd7);
    push(0, "w0_plain",  16'hABCD, 1'b1, 16'h0000, 1'b0);
    push(2, "zr_w0",     16'h0000, 1'b1, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'hABCD, 3'd0, 3'd7);
    push(0, "w7_plain",  16'hABCD, 1'b1, 16'hABCD, 1'b1);
    push(2, "zr_w7",     16'h0000, 1'b1, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7);
    push(2, "zr_read_0_7", 16'h0000, 1'b1, 16'h0000, 1'b0);
    tick();

    // Reset during a write drops it.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'hABCD, 3'd3, 3'd0);
    push(0, "rst_mid_byp", 16'h0000, 1'b0, 16'h0000, 1'b0);
    push(2, "rst_mid_zr",  16'h0000, 1'b0, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);
    push(0, "rst_lost_byp", 16'h0000, 1'b0, 16'h0000, 1'b0);
    push(1, "rst_lost_nob", 16'h0000, 1'b0, 16'h0000, 1'b0);
    push(2, "rst_lost_zr",  16'h0000, 1'b0, 16'h0000, 1'b1);
    tick();

    // Reset acts with the clock enable low.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h4242, 3'd4, 3'd4);
    push(0, "pre_rst_noen", 16'h4242, 1'b1, 16'h4242, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd4);
    push(0, "rst_noen",     16'h0000, 1'b0, 16'h0000, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
